ecc_secded_check_pipe: RTL

Pipelined read-side checker for the (72,64) SECDED code used on our memory data paths. It accepts 72-bit codewords on a valid/ready stream and returns corrected 64-bit data two cycles later with per-word status flags. It keeps saturating counts of correctable (CE) and uncorrectable (UE) errors, and captures the first error seen. It sits between the memory read port and the consumer, downstream of the encoder that produced the stored check bits.

---
 rtl/ecc_secded_check_pipe.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ecc_secded_check_pipe.sv
// ecc_secded_check_pipe
// Two-stage read-side checker for the (72,64) SECDED code.
// Stage 1 computes the syndrome and overall parity of the received word.
// Stage 2 classifies the word, corrects a single data-bit error, updates the
// saturating CE/UE counters and captures the first error in a one-entry log.
// The pipeline uses a valid/ready stream with a two-deep elastic structure.

module ecc_secded_check_pipe #(
  parameter int TAG_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [71:0]          s_code,
  input  logic [TAG_WIDTH-1:0] s_tag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [63:0]          m_data,
  output logic [TAG_WIDTH-1:0] m_tag,
  output logic                 m_ce,
  output logic                 m_ue,
  output logic [CNT_WIDTH-1:0] ce_count,
  output logic [CNT_WIDTH-1:0] ue_count,
  input  logic                 cnt_clear,
  output logic                 log_valid,
  output logic                 log_ue,
  output logic [7:0]           log_syndrome,
  output logic [TAG_WIDTH-1:0] log_tag,
  input  logic                 log_clear
);

  // Hamming position of data bit idx: the idx-th non-power-of-two in 1..71.
  function automatic logic [6:0] data_pos(input int idx);
    int         n;
    logic [6:0] r;
    n = 0;
    r = '0;
    for (int q = 1; q < 72; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (n == idx) r = 7'(q);
        n++;
      end
    end
    return r;
  endfunction

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Stage 1 registers
  logic                 v1_reg;
  logic [71:0]          code1_reg;
  logic [TAG_WIDTH-1:0] tag1_reg;
  logic [6:0]           syn1_reg;
  logic                 par1_reg;

  // Stage 2 / output registers
  logic                 m_valid_reg;
  logic [63:0]          m_data_reg;
  logic [TAG_WIDTH-1:0] m_tag_reg;
  logic                 m_ce_reg;
  logic                 m_ue_reg;

  // Counters and error log
  logic [CNT_WIDTH-1:0] ce_count_reg;
  logic [CNT_WIDTH-1:0] ue_count_reg;
  logic                 log_valid_reg;
  logic                 log_ue_reg;
  logic [7:0]           log_syndrome_reg;
  logic [TAG_WIDTH-1:0] log_tag_reg;

  // Per-check-bit coverage masks over the data bits and per-bit flip decode.
  logic [6:0][63:0] check_mask;
  logic [63:0]      flip_mask;
  logic [6:0]       check_calc;

  for (genvar gi = 0; gi < 64; gi++) begin : g_data_bit
    localparam logic [6:0] POS = data_pos(gi);
    for (genvar gk = 0; gk < 7; gk++) begin : g_mask
      assign check_mask[gk][gi] = POS[gk];
    end
    // A data bit is flipped only when the odd-weight syndrome points at it.
    assign flip_mask[gi] = par1_reg && (syn1_reg == POS);
  end

  for (genvar gk = 0; gk < 7; gk++) begin : g_check
    assign check_calc[gk] = ^(s_code[63:0] & check_mask[gk]);
  end

  // Stage-1 syndrome and overall parity of the incoming word.
  logic [6:0] syn_calc;
  logic       par_calc;
  assign syn_calc = check_calc ^ s_code[70:64];
  assign par_calc = ^s_code;

  // Classification of the word held in stage 1. Any odd-weight error whose
  // syndrome names a real position (0 = bit 71, powers of two = check bits,
  // others = data bits) is correctable; everything else is uncorrectable.
  logic syn_zero;
  logic syn_in_range;
  logic cls_ce;
  logic cls_ue;
  assign syn_zero     = (syn1_reg == 7'd0);
  assign syn_in_range = (syn1_reg <= 7'd71);
  assign cls_ce       = par1_reg && syn_in_range;
  assign cls_ue       = (par1_reg && !syn_in_range) || (!par1_reg && !syn_zero);

  // Stage advance control.
  logic load2;
  logic load1;
  logic ce_inc;
  logic ue_inc;
  logic log_capture;
  assign load2       = !m_valid_reg || m_ready;
  assign load1       = !v1_reg || load2;
  assign s_ready     = load1;
  assign ce_inc      = load2 && v1_reg && cls_ce;
  assign ue_inc      = load2 && v1_reg && cls_ue;
  assign log_capture = (ce_inc || ue_inc) && (!log_valid_reg || log_clear);

  // Stage 1: capture the raw word, tag, syndrome and parity.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      code1_reg <= '0;
      tag1_reg  <= '0;
      syn1_reg  <= '0;
      par1_reg  <= 1'b0;
    end else if (load1) begin
      v1_reg <= s_valid;
      if (s_valid) begin
        code1_reg <= s_code;
        tag1_reg  <= s_tag;
        syn1_reg  <= syn_calc;
        par1_reg  <= par_calc;
      end
    end
  end

  // Stage 2: register corrected data and status flags toward the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_tag_reg   <= '0;
      m_ce_reg    <= 1'b0;
      m_ue_reg    <= 1'b0;
    end else if (load2) begin
      m_valid_reg <= v1_reg;
      if (v1_reg) begin
        m_data_reg <= code1_reg[63:0] ^ flip_mask;
        m_tag_reg  <= tag1_reg;
        m_ce_reg   <= cls_ce;
        m_ue_reg   <= cls_ue;
      end
    end
  end

  // Saturating error counters; a clear coinciding with an increment leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_count_reg <= '0;
      ue_count_reg <= '0;
    end else if (cnt_clear) begin
      ce_count_reg <= ce_inc ? CNT_ONE : '0;
      ue_count_reg <= ue_inc ? CNT_ONE : '0;
    end else begin
      if (ce_inc && (ce_count_reg != '1)) ce_count_reg <= ce_count_reg + CNT_ONE;
      if (ue_inc && (ue_count_reg != '1)) ue_count_reg <= ue_count_reg + CNT_ONE;
    end
  end

  // First-error log; a new error arriving with log_clear replaces the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      log_valid_reg    <= 1'b0;
      log_ue_reg       <= 1'b0;
      log_syndrome_reg <= '0;
      log_tag_reg      <= '0;
    end else if (log_capture) begin
      log_valid_reg    <= 1'b1;
      log_ue_reg       <= cls_ue;
      log_syndrome_reg <= {par1_reg, syn1_reg};
      log_tag_reg      <= tag1_reg;
    end else if (log_clear) begin
      log_valid_reg <= 1'b0;
    end
  end

  assign m_valid      = m_valid_reg;
  assign m_data       = m_data_reg;
  assign m_tag        = m_tag_reg;
  assign m_ce         = m_ce_reg;
  assign m_ue         = m_ue_reg;
  assign ce_count     = ce_count_reg;
  assign ue_count     = ue_count_reg;
  assign log_valid    = log_valid_reg;
  assign log_ue       = log_ue_reg;
  assign log_syndrome = log_syndrome_reg;
  assign log_tag      = log_tag_reg;

endmodule
